rlc_decoder_core: RTL and testbench



---
 rtl/rlc_decoder_core.sv | 88 ++++++++
 tb/tb_rlc_decoder_core.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rlc_decoder_core.sv
// Run-length decoder: one 32-bit word of four (value, run) tokens expands into
// 4..32 four-bit symbols, emitted one per ready/valid beat, zero-extended to 32 bits.
module rlc_decoder_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int NUM_TOK = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state;
    logic [31:0] word_q;
    logic [1:0]  tok_idx;
    logic [2:0]  rep_cnt;

    logic [NUM_TOK-1:0][3:0] tok_val;
    logic [NUM_TOK-1:0][2:0] tok_run;
    logic [1:0]              nxt_idx;
    logic [2:0]              cur_run;
    logic                    accept;
    logic                    beat;
    logic                    unused_rsvd;

    // Token k sits 7 bits below token k-1, starting from the MSB.
    for (genvar k = 0; k < NUM_TOK; k++) begin : g_tok
        assign tok_val[k] = word_q[31-7*k -: 4];
        assign tok_run[k] = word_q[27-7*k -: 3];
    end

    assign unused_rsvd = ^word_q[3:0];

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign beat     = (state == EMIT) && out_valid && out_ready;
    assign cur_run  = tok_run[tok_idx];
    assign nxt_idx  = tok_idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word_q    <= '0;
            tok_idx   <= '0;
            rep_cnt   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q    <= in_data;
                        tok_idx   <= '0;
                        rep_cnt   <= '0;
                        // First symbol comes straight from the incoming word so it is valid next cycle.
                        out       <= {28'd0, in_data[31:28]};
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (beat) begin
                        if (rep_cnt < cur_run) begin
                            rep_cnt <= rep_cnt + 3'd1;
                        end else if (tok_idx != 2'd3) begin
                            tok_idx <= nxt_idx;
                            rep_cnt <= '0;
                            out     <= {28'd0, tok_val[nxt_idx]};
                        end else begin
                            out       <= '0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rlc_decoder_core.sv
// Self-checking bench for rlc_decoder_core: directed and random words checked
// against a token-expansion queue model, with stalls, mid-word reset and back-to-back words.
module tb_rlc_decoder_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    rlc_decoder_core dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] v0, input logic [2:0] r0,
                                         input logic [3:0] v1, input logic [2:0] r1,
                                         input logic [3:0] v2, input logic [2:0] r2,
                                         input logic [3:0] v3, input logic [2:0] r3);
        return {v0, r0, v1, r1, v2, r2, v3, r3, 4'h0};
    endfunction

    // Reference: each token contributes run+1 copies of its value, token 0 first.
    task automatic expand(input logic [31:0] w, output logic [3:0] q[$]);
        q = {};
        for (int k = 0; k < 4; k++) begin
            int v;
            int r;
            v = (w >> (28 - 7 * k)) & 32'hF;
            r = (w >> (25 - 7 * k)) & 32'h7;
            for (int i = 0; i <= r; i++) q.push_back(4'(v));
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the word.
    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic send(input logic [31:0] w, input int mode, input bit keep_valid);
        logic [3:0] q[$];
        logic [3:0] sym;
        int cyc;
        expand(w, q);
        in_data  = w;
        in_valid = 1'b1;
        chk("accept_rdy", {31'd0, in_ready}, 32'd1);
        chk("accept_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            in_data = $urandom;
            chk("emit_vld", {31'd0, out_valid}, 32'd1);
            chk("emit_in_rdy", {31'd0, in_ready}, 32'd0);
            chk("emit_sym", out, {28'd0, q[0]});
            @(posedge clk);
            if (out_ready) sym = q.pop_front();
            @(negedge clk);
        end
        chk("emit_timeout", q.size(), 32'd0);
        chk("end_in_rdy", {31'd0, in_ready}, 32'd1);
        chk("end_vld", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_in_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        send(32'h31E0A800, 0, 1'b0);
        send(pack(4'h7, 3'd7, 4'h2, 3'd0, 4'h9, 3'd0, 4'hC, 3'd0), 0, 1'b0);
        send(pack(4'h1, 3'd7, 4'h2, 3'd7, 4'h3, 3'd7, 4'h4, 3'd7), 0, 1'b0);
        w = $urandom;
        send(w, 1, 1'b0);
        send(w, 0, 1'b0);

        // Abandon a word after two accepted beats.
        in_data  = pack(4'h5, 3'd3, 4'h6, 3'd2, 4'h7, 3'd1, 4'h8, 3'd0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mid_b1", out, 32'h5);
        @(posedge clk);
        @(negedge clk);
        chk("mid_b2", out, 32'h5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out", out, 32'd0);
        chk("mid_rst_in_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rel_in_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rel_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        send(pack(4'hA, 3'd1, 4'hB, 3'd0, 4'hC, 3'd2, 4'hD, 3'd0), 0, 1'b0);

        // in_valid held high: second word taken in the first IDLE cycle.
        send(pack(4'h2, 3'd1, 4'h4, 3'd0, 4'h6, 3'd2, 4'h8, 3'd0), 0, 1'b1);
        send(pack(4'hE, 3'd0, 4'hD, 3'd3, 4'hC, 3'd0, 4'hB, 3'd1), 2, 1'b0);

        for (int i = 0; i < 20; i++) send($urandom, 2, i[0]);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
